// File: rtl/freq_sweep_scheduler.sv
// Frequency sweep scheduler.
// Steps the lock-in reference frequency from lo to hi in fixed increments.
// At each point it waits a settle time, requests one measurement, reports the
// completed point and then advances. While no sweep is running, the manual
// frequency passes through to the DDS with one cycle of latency.
module freq_sweep_scheduler #(
  parameter int FREQUENCY_RANGE = 8192,
  parameter int W               = 13,
  parameter int SETTLE_W        = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [W-1:0]        manual_freq,
  input  logic [W-1:0]        sweep_lo,
  input  logic [W-1:0]        sweep_hi,
  input  logic [W-1:0]        sweep_step,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                meas_done,
  output logic [W-1:0]        freq_out,
  output logic                meas_req,
  output logic                point_valid,
  output logic [W-1:0]        point_freq,
  output logic                busy,
  output logic                sweep_done,
  output logic                sweep_err
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    STEP,
    DONE
  } state_t;

  state_t              state;
  logic [W-1:0]        cur_freq;
  logic [W-1:0]        hi_q;
  logic [W-1:0]        step_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [SETTLE_W-1:0] settle_cnt;

  // The next point carries an extra bit so a step past the top of the code
  // space ends the sweep instead of wrapping back to a low frequency.
  logic [W:0] next_freq;
  logic       cfg_illegal;

  // Next sweep point and start-time configuration check.
  assign next_freq   = {1'b0, cur_freq} + {1'b0, step_q};
  assign cfg_illegal = (sweep_step == '0) || (sweep_lo > sweep_hi) ||
                       (32'(sweep_hi) >= 32'(FREQUENCY_RANGE));

  // Sweep sequencer: state, latched configuration and all registered outputs.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would let later statements in this
  // block see half-updated state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cur_freq    <= '0;
      hi_q        <= '0;
      step_q      <= '0;
      settle_q    <= '0;
      settle_cnt  <= '0;
      freq_out    <= '0;
      meas_req    <= 1'b0;
      point_valid <= 1'b0;
      point_freq  <= '0;
      busy        <= 1'b0;
      sweep_done  <= 1'b0;
      sweep_err   <= 1'b0;
    end else begin
      // Pulse outputs default low; the branches below raise them for one cycle.
      point_valid <= 1'b0;
      sweep_done  <= 1'b0;
      sweep_err   <= 1'b0;

      if (busy && abort) begin
        // Abort wins over a coincident meas_done and silently hands the bus back.
        state    <= IDLE;
        meas_req <= 1'b0;
        busy     <= 1'b0;
        freq_out <= manual_freq;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (cfg_illegal) begin
                state      <= DONE;
                sweep_done <= 1'b1;
                sweep_err  <= 1'b1;
              end else begin
                hi_q       <= sweep_hi;
                step_q     <= sweep_step;
                settle_q   <= settle_cycles;
                cur_freq   <= sweep_lo;
                freq_out   <= sweep_lo;
                settle_cnt <= settle_cycles;
                busy       <= 1'b1;
                state      <= SETTLE;
              end
            end else begin
              freq_out <= manual_freq;
            end
          end

          SETTLE: begin
            // A count of 0 or 1 both give a single settle cycle.
            if (settle_cnt > SETTLE_W'(1)) begin
              settle_cnt <= settle_cnt - SETTLE_W'(1);
            end else begin
              settle_cnt <= '0;
              meas_req   <= 1'b1;
              state      <= MEASURE;
            end
          end

          MEASURE: begin
            if (meas_done) begin
              meas_req    <= 1'b0;
              point_valid <= 1'b1;
              point_freq  <= cur_freq;
              state       <= STEP;
            end
          end

          STEP: begin
            if (next_freq > {1'b0, hi_q}) begin
              busy       <= 1'b0;
              sweep_done <= 1'b1;
              state      <= DONE;
            end else begin
              cur_freq   <= next_freq[W-1:0];
              freq_out   <= next_freq[W-1:0];
              settle_cnt <= settle_q;
              state      <= SETTLE;
            end
          end

          DONE: begin
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_sweep_scheduler.sv
// Self-checking bench for freq_sweep_scheduler.
// A table of sweep configurations drives full sweeps against a small lock-in
// responder; expected point frequencies go into a scoreboard queue at start
// and are popped as point_valid pulses arrive. Hand-written sequences cover
// zero settle, abort racing meas_done, and an asynchronous mid-sweep reset.
module tb_freq_sweep_scheduler;

  localparam int FR = 8192;
  localparam int W  = 13;
  localparam int SW = 16;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [W-1:0]  manual_freq;
  logic [W-1:0]  sweep_lo;
  logic [W-1:0]  sweep_hi;
  logic [W-1:0]  sweep_step;
  logic [SW-1:0] settle_cycles;
  logic          meas_done;
  logic [W-1:0]  freq_out;
  logic          meas_req;
  logic          point_valid;
  logic [W-1:0]  point_freq;
  logic          busy;
  logic          sweep_done;
  logic          sweep_err;

  freq_sweep_scheduler #(.FREQUENCY_RANGE(FR), .W(W), .SETTLE_W(SW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .manual_freq  (manual_freq),
    .sweep_lo     (sweep_lo),
    .sweep_hi     (sweep_hi),
    .sweep_step   (sweep_step),
    .settle_cycles(settle_cycles),
    .meas_done    (meas_done),
    .freq_out     (freq_out),
    .meas_req     (meas_req),
    .point_valid  (point_valid),
    .point_freq   (point_freq),
    .busy         (busy),
    .sweep_done   (sweep_done),
    .sweep_err    (sweep_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int lo;
    int hi;
    int step;
    int settle;
    int exp_err;
    int exp_npts;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one sweep from a negedge, answering each meas_req with meas_done
  // three cycles later, and checks the whole sweep against the record.
  task automatic run_sweep(input vec_t v);
    int cyc, first_req, req_age, npts, range_bad, err_wo_done;
    bit got_done, got_err, any_req, any_busy;
    int settle_eff;
    cyc = 0; first_req = -1; req_age = 0; npts = 0; range_bad = 0; err_wo_done = 0;
    got_done = 0; got_err = 0; any_req = 0; any_busy = 0;
    settle_eff = (v.settle < 1) ? 1 : v.settle;
    exp_q.delete();
    if (v.exp_err == 0) begin
      for (int f = v.lo; f <= v.hi; f += v.step) exp_q.push_back(f);
    end

    @(negedge clk);
    sweep_lo      = W'(v.lo);
    sweep_hi      = W'(v.hi);
    sweep_step    = W'(v.step);
    settle_cycles = SW'(v.settle);
    start         = 1'b1;

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cyc++;
      start     = 1'b0;
      meas_done = 1'b0;
      // Latched copies must be used; scramble the live config inputs.
      sweep_lo      = W'($urandom);
      sweep_hi      = W'($urandom);
      sweep_step    = W'($urandom);
      settle_cycles = SW'($urandom_range(0, 3));

      if (meas_req) begin
        if (!any_req) first_req = cyc;
        any_req = 1;
        req_age++;
        if (req_age == 3) meas_done = 1'b1;
      end else begin
        req_age = 0;
      end
      if (busy) begin
        any_busy = 1;
        if (int'(freq_out) < v.lo || int'(freq_out) > v.hi) range_bad++;
      end
      if (point_valid) begin
        npts++;
        if (exp_q.size() == 0) check("point_valid_unexpected", int'(point_freq), -1);
        else                   check("point_freq", int'(point_freq), exp_q.pop_front());
      end
      if (sweep_err && !sweep_done) err_wo_done++;
      if (sweep_done) begin
        got_done = 1;
        got_err  = sweep_err;
        break;
      end
    end
    meas_done = 1'b0;

    check("sweep_done_seen", int'(got_done), 1);
    check("sweep_err", int'(got_err), v.exp_err);
    check("point_count", npts, v.exp_npts);
    check("points_left", exp_q.size(), 0);
    check("err_without_done", err_wo_done, 0);
    if (v.exp_err != 0) begin
      check("err_meas_req_seen", int'(any_req), 0);
      check("err_busy_seen", int'(any_busy), 0);
    end else begin
      check("first_req_latency", first_req, settle_eff + 1);
      check("freq_out_range", range_bad, 0);
    end
    @(negedge clk);
    check("post_done_busy", int'(busy), 0);
    check("post_done_pulse", int'(sweep_done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{lo: 100,  hi: 130,  step: 10, settle: 4, exp_err: 0, exp_npts: 4};
    vecs[1] = '{lo: 8180, hi: 8191, step: 10, settle: 2, exp_err: 0, exp_npts: 2};
    vecs[2] = '{lo: 0,    hi: 0,    step: 5,  settle: 0, exp_err: 0, exp_npts: 1};
    vecs[3] = '{lo: 10,   hi: 35,   step: 10, settle: 1, exp_err: 0, exp_npts: 3};
    vecs[4] = '{lo: 10,   hi: 20,   step: 0,  settle: 3, exp_err: 1, exp_npts: 0};
    vecs[5] = '{lo: 50,   hi: 40,   step: 1,  settle: 3, exp_err: 1, exp_npts: 0};
    vecs[6] = '{lo: 100,  hi: 8192, step: 1,  settle: 3, exp_err: 1, exp_npts: 0};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; meas_done = 1'b0;
    manual_freq = '0; sweep_lo = '0; sweep_hi = '0; sweep_step = '0; settle_cycles = '0;
    repeat (3) @(negedge clk);
    check("reset_freq_out", int'(freq_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_meas_req", int'(meas_req), 0);
    check("reset_pulses", int'({point_valid, sweep_done, sweep_err}), 0);
    reset_n = 1'b1;

    // Manual tracking in IDLE with one cycle of latency; abort in IDLE ignored.
    @(negedge clk);
    manual_freq = W'(1234);
    abort       = 1'b1;
    #1 check("idle_before_edge", int'(freq_out), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("idle_track", int'(freq_out), 1234);
    check("idle_abort_busy", int'(busy), 0);

    // Zero settle, then abort racing meas_done.
    @(negedge clk);
    manual_freq = W'(777);
    sweep_lo = W'(200); sweep_hi = W'(300); sweep_step = W'(50); settle_cycles = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("s0_freq_out", int'(freq_out), 200);
    check("s0_meas_req_early", int'(meas_req), 0);
    check("s0_busy", int'(busy), 1);
    @(negedge clk);
    check("s0_meas_req", int'(meas_req), 1);
    abort = 1'b1; meas_done = 1'b1;
    @(negedge clk);
    abort = 1'b0; meas_done = 1'b0;
    check("abort_point_valid", int'(point_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_meas_req", int'(meas_req), 0);
    check("abort_sweep_done", int'(sweep_done), 0);
    @(negedge clk);
    check("abort_manual", int'(freq_out), 777);

    // Asynchronous reset between clock edges in the middle of SETTLE.
    sweep_lo = W'(500); sweep_hi = W'(600); sweep_step = W'(10); settle_cycles = SW'(20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_settle_busy", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_freq_out", int'(freq_out), 0);
    check("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    manual_freq = W'(321);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_release_manual", int'(freq_out), 321);
    check("rst_release_busy", int'(busy), 0);
    check("rst_release_meas_req", int'(meas_req), 0);

    for (int k = 0; k < 7; k++) run_sweep(vecs[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
